controle_vedacao: RTL
=====================

// Module: controle_vedacao
// PURPOSE
//  Sequences the corking station of the bottling line: stops the conveyor when a bottle is
//  at the station, fires the cork actuator, then releases the bottle. Keeps the cork stock
//  count and runs the depot refill handshake. Raises an alarm on refill failure.
//  Sits between the station sensors/actuators and the cork depot interface.
// PARAMETERS
//  W_ROLHAS    4   width of the cork stock counter
//  CAP_ROLHAS  15  magazine capacity; refills saturate here (must be <= 2^W_ROLHAS-1)
//  LIMIAR      2   idle refill threshold: a refill is requested when count <= LIMIAR
//  T_VEDACAO   3   actuator hold, in cycles (>=1)
//  T_TIMEOUT   64  max cycles to wait for ack_reposicao before alarm
// PORTS
//  clk              in   1         single clock, rising edge
//  rst_n            in   1         synchronous, active-low reset
//  sensor_garrafa   in   1         bottle present at station (level)
//  ack_reposicao    in   1         depot delivered; 1-cycle pulse, qualifies qtd_reposicao
//  qtd_reposicao    in   W_ROLHAS  corks delivered with ack
//  deposito_vazio   in   1         depot reports no stock (level)
//  limpar_alarme    in   1         operator clear (pulse)
//  esteira_liberada out  1         conveyor run enable
//  acionar_vedacao  out  1         cork actuator drive
//  req_reposicao    out  1         refill request (level, held until ack/abort)
//  contador_rolhas  out  W_ROLHAS  current cork stock
//  rolhas_ok        out  1         contador_rolhas != 0
//  alarme           out  1         refill failure flag
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state OCIOSO, contador_rolhas=0, all outputs 0 except
//    esteira_liberada=1. After reset, count 0 forces an immediate refill request.
//  - All outputs registered; every transition takes effect on the next clk edge.
//  - OCIOSO: esteira=1. Priority: (1) sensor_garrafa && count>0 -> VEDANDO;
//    (2) count==0 -> REPONDO; (3) !sensor_garrafa && count<=LIMIAR -> REPONDO.
//    A bottle present with count==0 goes to REPONDO; the conveyor stays stopped.
//  - VEDANDO: esteira=0, acionar=1 for exactly T_VEDACAO cycles. On exit, count decrements
//    by 1, then the FSM goes to LIBERANDO. The decrement never underflows: entry requires
//    count>0.
//  - LIBERANDO: acionar=0, esteira=1. Stay until sensor_garrafa==0, then go to OCIOSO.
//    This stops the same bottle being corked twice.
//  - REPONDO: req=1. esteira=0 if sensor_garrafa, else 1.
//    On ack: count = min(count + qtd_reposicao, CAP_ROLHAS), with the sum computed at
//    W_ROLHAS+1 bits. Then req=0 and the FSM goes to OCIOSO.
//    ack with qtd=0 also returns to OCIOSO, which re-requests if count is still low.
//  - REPONDO abort: if deposito_vazio, or the timeout counter reaches T_TIMEOUT,
//    go to ALARME with req=0. If ack and deposito_vazio arrive in the same cycle,
//    ack wins (count updated, return to OCIOSO).
//  - ALARME: alarme=1, esteira=0, acionar=0, req=0, count held. limpar_alarme -> OCIOSO
//    with alarme=0. A bottle may be corked later in OCIOSO if count>0.
//  - ack_reposicao outside REPONDO is ignored.
//  - rst_n low mid-operation (e.g. during VEDANDO) aborts at once: actuator off, count
//    cleared to 0.
// STRUCTURE
//  - Shared package holds the state encoding enum {OCIOSO, VEDANDO, LIBERANDO, REPONDO,
//    ALARME} and the default constants. The line status display decodes states from it.
//  - Sub-module temporizador (load/run/expired down-counter) is instantiated twice:
//    for T_VEDACAO and for T_TIMEOUT.
//  - Stock counter plus saturating add live in the top module; rolhas_ok = |contador_rolhas.
// TESTING
//  1 Reset, no bottle: req=1 at cycle 1. ack with qtd=10 -> count=10, req=0, rolhas_ok=1.
//  2 count=10, bottle held high: esteira=0, acionar=1 for 3 cycles, count=9.
//    Bottle still high -> no second actuation. Drop bottle -> OCIOSO.
//  3 count=14, ack with qtd=5 -> count saturates at 15, with no wrap to 3.
//  4 REPONDO with no ack for 64 cycles -> alarme=1, req=0, esteira=0.
//    limpar_alarme -> alarme=0, then a new req.
//  5 ack and deposito_vazio in the same cycle with qtd=4 -> count += 4, no alarm.
//    Bottle arriving at count=0 -> req=1, esteira=0, acionar stays 0.
//  6 rst_n=0 in the 2nd VEDANDO cycle -> next edge: acionar=0, count=0, esteira=1.

Source files
------------

// File: rtl/controle_vedacao_pkg.sv
// Shared definitions for the corking station controller.
// Holds the FSM state encoding (also decoded by the line status display)
// and the default parameter values used by the top module.
package controle_vedacao_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        VEDANDO   = 3'd1,
        LIBERANDO = 3'd2,
        REPONDO   = 3'd3,
        ALARME    = 3'd4
    } estado_t;

    localparam int W_ROLHAS_DEF   = 4;
    localparam int CAP_ROLHAS_DEF = 15;
    localparam int LIMIAR_DEF     = 2;
    localparam int T_VEDACAO_DEF  = 3;
    localparam int T_TIMEOUT_DEF  = 64;

endpackage

// File: rtl/controle_vedacao_temporizador.sv
// Load/run down-counter used for the actuator hold and the refill timeout.
//   clk, rst_n   : clock, synchronous active-low reset
//   carregar_i   : load valor_i (has priority over counting)
//   valor_i      : load value; expirado_o rises valor_i cycles after the load
//   rodar_i      : count down while high, stopping at zero
//   expirado_o   : counter is at zero
module controle_vedacao_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carregar_i,
    input  logic [W-1:0] valor_i,
    input  logic         rodar_i,
    output logic         expirado_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carregar_i)
            cnt_d = valor_i;
        else if (rodar_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expirado_o = (cnt_q == '0);

endmodule

// File: rtl/controle_vedacao.sv
// Corking station sequencer: stops the conveyor for a bottle, fires the cork
// actuator, releases the bottle, tracks cork stock and runs the depot refill
// handshake with timeout/empty-depot alarm.
//   sensor_garrafa   : bottle present (level)
//   ack_reposicao    : depot delivery pulse, qualifies qtd_reposicao
//   qtd_reposicao    : corks delivered
//   deposito_vazio   : depot empty (level)
//   limpar_alarme    : operator alarm clear
//   esteira_liberada : conveyor enable
//   acionar_vedacao  : cork actuator
//   req_reposicao    : refill request
//   contador_rolhas  : cork stock
//   rolhas_ok        : stock non-zero
//   alarme           : refill failure
// All outputs are registered from the next state.
module controle_vedacao
    import controle_vedacao_pkg::*;
#(
    parameter int W_ROLHAS   = W_ROLHAS_DEF,
    parameter int CAP_ROLHAS = CAP_ROLHAS_DEF,
    parameter int LIMIAR     = LIMIAR_DEF,
    parameter int T_VEDACAO  = T_VEDACAO_DEF,
    parameter int T_TIMEOUT  = T_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sensor_garrafa,
    input  logic                ack_reposicao,
    input  logic [W_ROLHAS-1:0] qtd_reposicao,
    input  logic                deposito_vazio,
    input  logic                limpar_alarme,
    output logic                esteira_liberada,
    output logic                acionar_vedacao,
    output logic                req_reposicao,
    output logic [W_ROLHAS-1:0] contador_rolhas,
    output logic                rolhas_ok,
    output logic                alarme
);

    localparam logic [W_ROLHAS-1:0] CAP_W    = W_ROLHAS'(CAP_ROLHAS);
    localparam logic [W_ROLHAS-1:0] LIMIAR_W = W_ROLHAS'(LIMIAR);
    localparam int                  TW_V     = $clog2(T_VEDACAO + 1);
    localparam int                  TW_T     = $clog2(T_TIMEOUT + 1);
    // Loaded with T-1 on entry: the state is left on the cycle the counter
    // reads zero, giving exactly T cycles in the state.
    localparam logic [TW_V-1:0]     CARGA_V  = TW_V'(T_VEDACAO - 1);
    localparam logic [TW_T-1:0]     CARGA_T  = TW_T'(T_TIMEOUT - 1);

    estado_t             state_q, state_d;
    logic [W_ROLHAS-1:0] count_q, count_d;
    logic [W_ROLHAS:0]   soma;
    logic [W_ROLHAS-1:0] soma_sat;
    logic                exp_v, exp_t;
    logic                esteira_d, acionar_d, req_d, alarme_d;
    logic                esteira_q, acionar_q, req_q, alarme_q, ok_q;

    // Sum one bit wider so an overflowing delivery saturates instead of wrapping.
    assign soma     = {1'b0, count_q} + {1'b0, qtd_reposicao};
    assign soma_sat = (soma > {1'b0, CAP_W}) ? CAP_W : soma[W_ROLHAS-1:0];

    controle_vedacao_temporizador #(.W(TW_V)) u_tmr_vedacao (
        .clk        (clk),
        .rst_n      (rst_n),
        .carregar_i ((state_d == VEDANDO) && (state_q != VEDANDO)),
        .valor_i    (CARGA_V),
        .rodar_i    (state_q == VEDANDO),
        .expirado_o (exp_v)
    );

    controle_vedacao_temporizador #(.W(TW_T)) u_tmr_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .carregar_i ((state_d == REPONDO) && (state_q != REPONDO)),
        .valor_i    (CARGA_T),
        .rodar_i    (state_q == REPONDO),
        .expirado_o (exp_t)
    );

    // State, stock and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= OCIOSO;
            count_q   <= '0;
            esteira_q <= 1'b1;
            acionar_q <= 1'b0;
            req_q     <= 1'b0;
            alarme_q  <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            esteira_q <= esteira_d;
            acionar_q <= acionar_d;
            req_q     <= req_d;
            alarme_q  <= alarme_d;
            ok_q      <= |count_d;
        end
    end

    // Next state and stock update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            OCIOSO: begin
                if (sensor_garrafa && (count_q != '0))         state_d = VEDANDO;
                else if (count_q == '0)                        state_d = REPONDO;
                else if (!sensor_garrafa && count_q <= LIMIAR_W) state_d = REPONDO;
            end
            VEDANDO: begin
                if (exp_v) begin
                    count_d = count_q - W_ROLHAS'(1);
                    state_d = LIBERANDO;
                end
            end
            LIBERANDO: begin
                if (!sensor_garrafa) state_d = OCIOSO;
            end
            REPONDO: begin
                // A delivery beats a simultaneous empty/timeout abort.
                if (ack_reposicao) begin
                    count_d = soma_sat;
                    state_d = OCIOSO;
                end else if (deposito_vazio || exp_t) begin
                    state_d = ALARME;
                end
            end
            ALARME: begin
                if (limpar_alarme) state_d = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // Output decode from the next state, registered above
    always_comb begin
        esteira_d = 1'b1;
        acionar_d = 1'b0;
        req_d     = 1'b0;
        alarme_d  = 1'b0;
        case (state_d)
            VEDANDO: begin
                esteira_d = 1'b0;
                acionar_d = 1'b1;
            end
            REPONDO: begin
                req_d     = 1'b1;
                esteira_d = !sensor_garrafa;
            end
            ALARME: begin
                esteira_d = 1'b0;
                alarme_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign esteira_liberada = esteira_q;
    assign acionar_vedacao  = acionar_q;
    assign req_reposicao    = req_q;
    assign contador_rolhas  = count_q;
    assign rolhas_ok        = ok_q;
    assign alarme           = alarme_q;

endmodule
